regfile_checker: RTL and testbench

- Hardware end-of-run result checker for the MIPS single-cycle core.
- After a program run, it reads GPRs FIRST_REG..LAST_REG one per cycle through a read port. It compares each against an expected-value table addressed by the same index.
- It reports pass/fail, the first failing register with its got/expected values, and a mismatch count.
- Sits beside the processor on the GPR debug read port; lets self-checking runs work on FPGA without a simulator bench.

---
 rtl/regfile_checker.sv | 119 +++++++++++
 tb/tb_regfile_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_checker.sv
// regfile_checker: end-of-run GPR result checker.
// Walks GPRs FIRST_REG..LAST_REG one per cycle through the debug read port,
// compares each against an expected-value table at the same index, and
// reports pass/fail, the first failing register and a saturating mismatch
// count.
// Optional build macro: REGCHK_STOP_ON_FAIL_EN -- when defined, the scan
// ends at the first mismatch instead of covering the whole range.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; results of the last scan held
// SCAN   | rf_addr = idx, one compare per cycle
// DONE   | one-cycle done pulse, pass valid
module regfile_checker #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [WIDTH-1:0]  rf_data,
  input  logic [WIDTH-1:0]  exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [WIDTH-1:0]  fail_got,
  output logic [WIDTH-1:0]  fail_exp,
  output logic [5:0]        mismatch_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(LAST_REG);

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic              mism;
  logic              scan_end;
  logic [5:0]        cnt_next;

  // Compare and end-of-scan decode; case inequality so X/Z reads count as mismatches
  always_comb begin
    mism     = (rf_data !== exp_data);
    cnt_next = mismatch_cnt;
    if (mism && (mismatch_cnt != 6'd63)) begin
      cnt_next = mismatch_cnt + 6'd1;
    end
`ifdef REGCHK_STOP_ON_FAIL_EN
    scan_end = (idx == IDX_LAST) || mism;
`else
    scan_end = (idx == IDX_LAST);
`endif
  end

  // Read index and status decode from state
  always_comb begin
    busy    = (state == S_SCAN);
    done    = (state == S_DONE);
    rf_addr = busy ? idx : '0;
  end

  // Scan sequencer and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      pass         <= 1'b0;
      fail_idx     <= '0;
      fail_got     <= '0;
      fail_exp     <= '0;
      mismatch_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx          <= IDX_FIRST;
            pass         <= 1'b0;
            fail_idx     <= '0;
            fail_got     <= '0;
            fail_exp     <= '0;
            mismatch_cnt <= '0;
            state        <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (mism) begin
            mismatch_cnt <= cnt_next;
            // count is still zero only before the first mismatch of this scan
            if (mismatch_cnt == 6'd0) begin
              fail_idx <= idx;
              fail_got <= rf_data;
              fail_exp <= exp_data;
            end
          end
          if (scan_end) begin
            pass  <= (cnt_next == 6'd0);
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_checker.sv
// Testbench for regfile_checker: scan-level reference model plus directed
// and randomized register images.
module tb_regfile_checker;

  localparam int WIDTH = 32;
  localparam int ADDR_W = 5;
  localparam int FIRST = 1;
  localparam int LAST = 31;
`ifdef REGCHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk;
  logic reset;
  logic start;
  logic [ADDR_W-1:0] rf_addr;
  logic [WIDTH-1:0] rf_data;
  logic [WIDTH-1:0] exp_data;
  logic busy, done, pass;
  logic [ADDR_W-1:0] fail_idx;
  logic [WIDTH-1:0] fail_got, fail_exp;
  logic [5:0] mismatch_cnt;

  logic [WIDTH-1:0] rf_mem [32];
  logic [WIDTH-1:0] exp_mem [32];

  assign rf_data  = rf_mem[rf_addr];
  assign exp_data = exp_mem[rf_addr];

  regfile_checker #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rf_addr(rf_addr), .rf_data(rf_data), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass),
    .fail_idx(fail_idx), .fail_got(fail_got), .fail_exp(fail_exp),
    .mismatch_cnt(mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: t = cycle index within the current scan (0 = idle),
  // L = number of SCAN cycles, results computed once per accepted start.
  int t = 0;
  int L = 0;
  bit m_pass = 0;
  int m_idx = 0;
  logic [WIDTH-1:0] m_got = '0, m_exp = '0;
  int m_cnt = 0;
  bit p_pass;
  int p_idx, p_cnt;
  logic [WIDTH-1:0] p_got, p_exp;

  always @(posedge clk) begin
    if (reset) begin
      t = 0; m_pass = 0; m_idx = 0; m_got = '0; m_exp = '0; m_cnt = 0;
    end else if (t == 0) begin
      if (start) begin
        L = 0; p_cnt = 0; p_idx = 0; p_got = '0; p_exp = '0;
        for (int i = FIRST; i <= LAST; i++) begin
          L++;
          if (rf_mem[i] !== exp_mem[i]) begin
            if (p_cnt == 0) begin
              p_idx = i; p_got = rf_mem[i]; p_exp = exp_mem[i];
            end
            p_cnt = (p_cnt < 63) ? p_cnt + 1 : 63;
            if (STOP) break;
          end
        end
        p_pass = (p_cnt == 0);
        m_pass = 0; m_idx = 0; m_got = '0; m_exp = '0; m_cnt = 0;
        t = 1;
      end
    end else if (t == L) begin
      t = L + 1;
      m_pass = p_pass; m_idx = p_idx; m_got = p_got; m_exp = p_exp; m_cnt = p_cnt;
    end else if (t == L + 1) begin
      t = 0;
    end else begin
      t++;
    end
  end

  // Per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    bit e_busy;
    e_busy = (t >= 1) && (t <= L);
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(t == L + 1 && t != 0));
    chk("rf_addr", 64'(rf_addr), e_busy ? 64'(FIRST + t - 1) : 64'd0);
    if (e_busy) begin
      chk("pass_during_scan", 64'(pass), 64'd0);
    end else begin
      chk("pass", 64'(pass), 64'(m_pass));
      chk("fail_idx", 64'(fail_idx), 64'(m_idx));
      chk("fail_got", 64'(fail_got), 64'(m_got));
      chk("fail_exp", 64'(fail_exp), 64'(m_exp));
      chk("mismatch_cnt", 64'(mismatch_cnt), 64'(m_cnt));
    end
  end

  task automatic fill();
    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = (i == 0) ? 32'h0 : 32'hcafebabe;
    end
    exp_mem[2] = 32'h00000005;
    for (int i = 0; i < 32; i++) rf_mem[i] = exp_mem[i];
  endtask

  // Start a scan; runs a fixed 40-cycle window, optionally re-pulsing start
  // or pulsing reset at the given cycle numbers (cycle 0 = start cycle).
  task automatic run(input int restart_at, input int reset_at, output int done_at, output int ndone);
    @(negedge clk);
    start = 1'b1;
    done_at = -1;
    ndone = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == restart_at);
      reset = (n == reset_at);
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = n;
      end
      if (reset_at > 0 && n == reset_at + 1) begin
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rf_addr", 64'(rf_addr), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_cnt", 64'(mismatch_cnt), 64'd0);
      end
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  int d, nd, k;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill();
    repeat (3) @(negedge clk);
    chk("reset_pass", 64'(pass), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // 1: all match
    run(-1, -1, d, nd);
    chk("t1_done_at", 64'(d), 64'd32);
    chk("t1_ndone", 64'(nd), 64'd1);
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_cnt", 64'(mismatch_cnt), 64'd0);
    chk("t1_fail_idx", 64'(fail_idx), 64'd0);

    // 2: reg 7 zero
    rf_mem[7] = 32'h0;
    run(-1, -1, d, nd);
    chk("t2_done_at", 64'(d), STOP ? 64'd8 : 64'd32);
    chk("t2_pass", 64'(pass), 64'd0);
    chk("t2_fail_idx", 64'(fail_idx), 64'd7);
    chk("t2_fail_got", 64'(fail_got), 64'h0);
    chk("t2_fail_exp", 64'(fail_exp), 64'hcafebabe);
    chk("t2_cnt", 64'(mismatch_cnt), 64'd1);

    // 3: regs 3 and 20, then boundary reg 31
    fill();
    rf_mem[3] = 32'h1;
    rf_mem[20] = 32'h2;
    run(-1, -1, d, nd);
    chk("t3_fail_idx", 64'(fail_idx), 64'd3);
    chk("t3_cnt", 64'(mismatch_cnt), STOP ? 64'd1 : 64'd2);
    fill();
    rf_mem[31] = 32'h3;
    run(-1, -1, d, nd);
    chk("t3b_fail_idx", 64'(fail_idx), 64'd31);
    chk("t3b_done_at", 64'(d), 64'd32);
    chk("t3b_fail_got", 64'(fail_got), 64'h3);

    // 4: start pulsed mid-scan is ignored; repeat scan gives the same result
    fill();
    rf_mem[9] = 32'h9;
    run(5, -1, d, nd);
    chk("t4_ndone", 64'(nd), 64'd1);
    chk("t4_done_at", 64'(d), STOP ? 64'd10 : 64'd32);
    chk("t4_fail_idx", 64'(fail_idx), 64'd9);
    run(-1, -1, d, nd);
    chk("t4b_fail_idx", 64'(fail_idx), 64'd9);
    chk("t4b_cnt", 64'(mismatch_cnt), 64'd1);

    // 5: reset while rf_addr = 10
    fill();
    run(-1, 10, d, nd);
    chk("t5_ndone", 64'(nd), 64'd0);
    run(-1, -1, d, nd);
    chk("t5b_done_at", 64'(d), 64'd32);
    chk("t5b_pass", 64'(pass), 64'd1);

    // 6: unknown data at reg 12
    fill();
    rf_mem[12] = 'x;
    run(-1, -1, d, nd);
    chk("t6_fail_idx", 64'(fail_idx), 64'd12);
    chk("t6_pass", 64'(pass), 64'd0);

    // randomized images
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 32; i++) exp_mem[i] = $urandom;
      for (int i = 0; i < 32; i++) rf_mem[i] = exp_mem[i];
      k = $urandom_range(0, 5);
      for (int j = 0; j < k; j++) begin
        rf_mem[$urandom_range(0, 31)] ^= (32'h1 << $urandom_range(0, 31));
      end
      run((it % 3 == 0) ? int'($urandom_range(1, 30)) : -1, -1, d, nd);
      chk("rnd_ndone", 64'(nd), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
